// File: rtl/swc_alloc_port_arbiter.sv
// Round-robin arbiter that funnels per-port page alloc/free/force_free/set_usecnt
// requests into a single allocator core, one operation per grant.
module swc_alloc_port_arbiter #(
    parameter int g_num_ports       = 7,
    parameter int g_page_addr_width = 10,
    parameter int g_usecount_width  = 4
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [g_num_ports-1:0]                     alloc_i,
    input  logic [g_num_ports-1:0]                     free_i,
    input  logic [g_num_ports-1:0]                     force_free_i,
    input  logic [g_num_ports-1:0]                     set_usecnt_i,
    input  logic [g_num_ports*g_page_addr_width-1:0]   pgaddr_free_i,
    input  logic [g_num_ports*g_page_addr_width-1:0]   pgaddr_force_free_i,
    input  logic [g_num_ports*g_page_addr_width-1:0]   pgaddr_usecnt_i,
    input  logic [g_num_ports*g_usecount_width-1:0]    usecnt_i,
    output logic [g_num_ports-1:0]                     alloc_done_o,
    output logic [g_num_ports-1:0]                     free_done_o,
    output logic [g_num_ports-1:0]                     force_free_done_o,
    output logic [g_num_ports-1:0]                     set_usecnt_done_o,
    output logic [g_page_addr_width-1:0]               pgaddr_alloc_o,
    output logic                                       core_req_o,
    output logic [1:0]                                 core_op_o,
    output logic [g_page_addr_width-1:0]               core_pgaddr_o,
    output logic [g_usecount_width-1:0]                core_usecnt_o,
    input  logic                                       core_ack_i,
    input  logic [g_page_addr_width-1:0]               core_pgaddr_i,
    output logic                                       busy_o
);

    localparam int A  = g_page_addr_width;
    localparam int U  = g_usecount_width;
    localparam int GW = (g_num_ports > 1) ? $clog2(g_num_ports) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
    typedef enum logic [1:0] {
        OP_ALLOC      = 2'b00,
        OP_FREE       = 2'b01,
        OP_FORCE_FREE = 2'b10,
        OP_SET_USECNT = 2'b11
    } op_t;

    state_t state, state_nxt;
    op_t    op_q, op_sel;

    // last_grant doubles as the index of the port being served while busy
    logic [GW-1:0]          last_grant, sel, cand;
    logic                   found;
    logic [g_num_ports-1:0] pending;
    logic [A-1:0]           addr_sel;
    logic [U-1:0]           cnt_sel;

    logic [A-1:0] free_addr   [g_num_ports];
    logic [A-1:0] force_addr  [g_num_ports];
    logic [A-1:0] usecnt_addr [g_num_ports];
    logic [U-1:0] usecnt_val  [g_num_ports];

    for (genvar i = 0; i < g_num_ports; i++) begin : g_unpack
        assign free_addr[i]   = pgaddr_free_i[i*A +: A];
        assign force_addr[i]  = pgaddr_force_free_i[i*A +: A];
        assign usecnt_addr[i] = pgaddr_usecnt_i[i*A +: A];
        assign usecnt_val[i]  = usecnt_i[i*U +: U];
    end

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path infers a latch.
        pending = alloc_i | free_i | force_free_i | set_usecnt_i;
        found   = 1'b0;
        sel     = last_grant;
        cand    = '0;
        for (int k = 1; k <= g_num_ports; k++) begin
            cand = GW'((int'(last_grant) + k) % g_num_ports);
            if (!found && pending[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        op_sel   = OP_ALLOC;
        addr_sel = '0;
        cnt_sel  = '0;
        if (force_free_i[sel]) begin
            op_sel   = OP_FORCE_FREE;
            addr_sel = force_addr[sel];
        end else if (free_i[sel]) begin
            op_sel   = OP_FREE;
            addr_sel = free_addr[sel];
        end else if (set_usecnt_i[sel]) begin
            op_sel   = OP_SET_USECNT;
            addr_sel = usecnt_addr[sel];
            cnt_sel  = usecnt_val[sel];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (found) state_nxt = S_REQ;
            S_REQ:   if (core_ack_i) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant        <= GW'(g_num_ports - 1);
            op_q              <= OP_ALLOC;
            core_pgaddr_o     <= '0;
            core_usecnt_o     <= '0;
            pgaddr_alloc_o    <= '0;
            alloc_done_o      <= '0;
            free_done_o       <= '0;
            force_free_done_o <= '0;
            set_usecnt_done_o <= '0;
        end else begin
            alloc_done_o      <= '0;
            free_done_o       <= '0;
            force_free_done_o <= '0;
            set_usecnt_done_o <= '0;
            if (state == S_IDLE && found) begin
                last_grant    <= sel;
                op_q          <= op_sel;
                core_pgaddr_o <= addr_sel;
                core_usecnt_o <= cnt_sel;
            end
            if (state == S_REQ && core_ack_i) begin
                unique case (op_q)
                    OP_ALLOC: begin
                        alloc_done_o[last_grant] <= 1'b1;
                        pgaddr_alloc_o           <= core_pgaddr_i;
                    end
                    OP_FREE:       free_done_o[last_grant]       <= 1'b1;
                    OP_FORCE_FREE: force_free_done_o[last_grant] <= 1'b1;
                    OP_SET_USECNT: set_usecnt_done_o[last_grant] <= 1'b1;
                endcase
            end
        end
    end

    // Combinational from state so reset drops the core request without waiting for a clock
    assign core_req_o = (state == S_REQ);
    assign busy_o     = (state != S_IDLE);
    assign core_op_o  = op_q;

endmodule

// File: tb/tb_swc_alloc_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomised traffic against a
// page-pool model of the allocator core, checked through a completion scoreboard.
module tb_swc_alloc_port_arbiter;

    localparam int N    = 7;
    localparam int A    = 10;
    localparam int U    = 4;
    localparam int POOL = 16;
    localparam logic [1:0] OP_ALLOC = 2'b00, OP_FREE = 2'b01, OP_FORCE = 2'b10, OP_SET = 2'b11;

    typedef struct {
        int         port;
        logic [1:0] op;
        logic [A-1:0] addr;
        logic [U-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]   alloc_r = '0, free_r = '0, force_r = '0, set_r = '0;
    logic [N*A-1:0] pg_free = '0, pg_force = '0, pg_use = '0;
    logic [N*U-1:0] ucnt_in = '0;
    logic [N-1:0]   alloc_done, free_done, force_done, set_done;
    logic [A-1:0]   pgaddr_alloc, core_pgaddr, core_pgaddr_in = '0;
    logic [U-1:0]   core_usecnt;
    logic [1:0]     core_op;
    logic           core_req, core_ack = 1'b0, busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    exp_t         sb[$];
    logic [A-1:0] free_pages[$];
    int           ucnt[1 << A];

    // core model controls and record of the transaction it last acknowledged
    int           ack_delay = 0;
    logic         ack_rand = 1'b0, model_en = 1'b0, in_req = 1'b0, prev_any = 1'b0;
    int           stall = 0;
    logic [A-1:0] pg_val = '0, srv_addr = '0, srv_page = '0;
    logic [1:0]   srv_op = '0;
    logic [U-1:0] srv_cnt = '0;

    swc_alloc_port_arbiter #(
        .g_num_ports(N), .g_page_addr_width(A), .g_usecount_width(U)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .alloc_i(alloc_r), .free_i(free_r), .force_free_i(force_r), .set_usecnt_i(set_r),
        .pgaddr_free_i(pg_free), .pgaddr_force_free_i(pg_force), .pgaddr_usecnt_i(pg_use),
        .usecnt_i(ucnt_in),
        .alloc_done_o(alloc_done), .free_done_o(free_done),
        .force_free_done_o(force_done), .set_usecnt_done_o(set_done),
        .pgaddr_alloc_o(pgaddr_alloc),
        .core_req_o(core_req), .core_op_o(core_op),
        .core_pgaddr_o(core_pgaddr), .core_usecnt_o(core_usecnt),
        .core_ack_i(core_ack), .core_pgaddr_i(core_pgaddr_in),
        .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int first_bit(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic push_exp(input int p, input logic [1:0] op, input logic [A-1:0] addr,
                            input logic [U-1:0] cnt);
        exp_t e;
        e.port = p;
        e.op   = op;
        e.addr = (op == OP_ALLOC) ? '0 : addr;
        e.cnt  = (op == OP_SET) ? cnt : '0;
        sb.push_back(e);
    endtask

    task automatic raise(input int p, input logic [1:0] op, input logic [A-1:0] addr,
                         input logic [U-1:0] cnt);
        push_exp(p, op, addr, cnt);
        case (op)
            OP_ALLOC: alloc_r[p] = 1'b1;
            OP_FREE:  begin pg_free[p*A +: A] = addr; free_r[p] = 1'b1; end
            OP_FORCE: begin pg_force[p*A +: A] = addr; force_r[p] = 1'b1; end
            default:  begin pg_use[p*A +: A] = addr; ucnt_in[p*U +: U] = cnt; set_r[p] = 1'b1; end
        endcase
    endtask

    // Waits for the done pulse of (port, op), then drops that request bit within the DONE cycle
    task automatic wait_done(input int p, input logic [1:0] op, output int c,
                             output logic [A-1:0] pg, output logic [N-1:0] vec);
        logic hit;
        hit = 1'b0; c = -1; pg = '0; vec = '0;
        for (int t = 0; t < 400 && !hit; t++) begin
            @(negedge clk);
            case (op)
                OP_ALLOC: vec = alloc_done;
                OP_FREE:  vec = free_done;
                OP_FORCE: vec = force_done;
                default:  vec = set_done;
            endcase
            hit = vec[p];
        end
        check("done_timeout", hit, 1'b1);
        if (hit) begin
            c  = cyc;
            pg = pgaddr_alloc;
            case (op)
                OP_ALLOC: alloc_r[p] = 1'b0;
                OP_FREE:  free_r[p]  = 1'b0;
                OP_FORCE: force_r[p] = 1'b0;
                default:  set_r[p]   = 1'b0;
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic port_job(input int p);
        int c, k;
        logic [A-1:0] pg, dummy;
        logic [N-1:0] vec;
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            raise(p, OP_ALLOC, '0, '0);
            wait_done(p, OP_ALLOC, c, pg, vec);
            k = $urandom_range(1, 3);
            case ($urandom_range(0, 2))
                0: begin
                    raise(p, OP_SET, pg, U'(k));
                    wait_done(p, OP_SET, c, dummy, vec);
                    repeat (k) begin
                        raise(p, OP_FREE, pg, '0);
                        wait_done(p, OP_FREE, c, dummy, vec);
                    end
                end
                1: begin
                    raise(p, OP_FREE, pg, '0);
                    wait_done(p, OP_FREE, c, dummy, vec);
                end
                default: begin
                    raise(p, OP_FORCE, pg, '0);
                    wait_done(p, OP_FORCE, c, dummy, vec);
                end
            endcase
        end
    endtask

    // Allocator core model: acks after a programmable stall and tracks the page pool
    always @(negedge clk) begin
        int s;
        logic [A-1:0] page;
        core_ack <= 1'b0;
        if (rst) begin
            in_req <= 1'b0;
        end else if (core_req) begin
            s = in_req ? stall : (ack_rand ? int'($urandom_range(0, 3)) : ack_delay);
            if (s == 0) begin
                page = pg_val;
                if (model_en) begin
                    case (core_op)
                        OP_ALLOC: begin
                            page = (free_pages.size() > 0) ? free_pages.pop_front() : '0;
                            ucnt[page] <= 1;
                        end
                        OP_FREE: if (ucnt[core_pgaddr] != 0) begin
                            ucnt[core_pgaddr] <= ucnt[core_pgaddr] - 1;
                            if (ucnt[core_pgaddr] == 1) free_pages.push_back(core_pgaddr);
                        end
                        OP_FORCE: if (ucnt[core_pgaddr] != 0) begin
                            ucnt[core_pgaddr] <= 0;
                            free_pages.push_back(core_pgaddr);
                        end
                        default: ucnt[core_pgaddr] <= int'(core_usecnt);
                    endcase
                end
                in_req         <= 1'b0;
                core_ack       <= 1'b1;
                core_pgaddr_in <= page;
                srv_op         <= core_op;
                srv_addr       <= core_pgaddr;
                srv_cnt        <= core_usecnt;
                srv_page       <= page;
            end else begin
                in_req <= 1'b1;
                stall  <= s - 1;
            end
        end
    end

    // Completion monitor: every done pulse must match the oldest expectation for its port
    always @(negedge clk) begin
        logic [4*N-1:0] all;
        logic [1:0] op;
        int p, idx;
        all = {set_done, force_done, free_done, alloc_done};
        if (!rst && (|all)) begin
            check("done_onehot", $countones(all), 1);
            check("done_width", prev_any, 1'b0);
            op  = (|alloc_done) ? OP_ALLOC : (|free_done) ? OP_FREE :
                  (|force_done) ? OP_FORCE : OP_SET;
            p   = first_bit(alloc_done | free_done | force_done | set_done);
            idx = -1;
            for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].port == p) idx = i;
            check("sb_expected", idx >= 0, 1'b1);
            if (idx >= 0) begin
                check("sb_done_op", op, sb[idx].op);
                check("sb_core_op", srv_op, sb[idx].op);
                check("sb_core_pgaddr", srv_addr, sb[idx].addr);
                check("sb_core_usecnt", srv_cnt, sb[idx].cnt);
                if (sb[idx].op == OP_ALLOC) check("sb_pgaddr_alloc", pgaddr_alloc, srv_page);
                sb.delete(idx);
            end
        end
        prev_any <= !rst && (|all);
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, n;
        int fair_port[8];
        int fair_cyc[8];
        logic got;
        logic [A-1:0] pg;
        logic [N-1:0] vec;

        for (int i = 0; i < POOL; i++) free_pages.push_back(A'(32 + i));

        repeat (2) @(negedge clk);
        check("rst_core_outs", {core_req, busy, core_op, core_pgaddr, core_usecnt}, '0);
        check("rst_done", {alloc_done, free_done, force_done, set_done}, '0);
        check("rst_pgaddr_alloc", pgaddr_alloc, '0);
        rst = 1'b0;

        // single alloc on port 2
        pg_val = 10'h155;
        @(negedge clk);
        c0 = cyc;
        raise(2, OP_ALLOC, '0, '0);
        wait_done(2, OP_ALLOC, c1, pg, vec);
        check("alloc_latency", c1 - c0, 2);
        check("alloc_done_vec", vec, 7'b0000100);
        check("alloc_pgaddr", pg, 10'h155);
        pg_val = 10'h2AA;
        repeat (5) @(negedge clk);
        check("alloc_pgaddr_hold", pgaddr_alloc, 10'h155);

        // fairness after reset: 0..6 then 0, three cycles apart
        do_reset();
        for (int i = 0; i < 8; i++) push_exp(i % N, OP_ALLOC, '0, '0);
        alloc_r = '1;
        n = 0;
        for (int t = 0; t < 100 && n < 8; t++) begin
            @(negedge clk);
            if (|alloc_done) begin
                fair_port[n] = first_bit(alloc_done);
                fair_cyc[n]  = cyc;
                n++;
                if (n == 8) alloc_r = '0;
            end
        end
        check("fair_count", n, 8);
        for (int i = 0; i < n; i++) begin
            check("fair_port", fair_port[i], i % N);
            if (i > 0) check("fair_gap", fair_cyc[i] - fair_cyc[i-1], 3);
        end

        // op priority: free beats alloc on the same port
        raise(4, OP_FREE, 10'h3FF, '0);
        raise(4, OP_ALLOC, '0, '0);
        wait_done(4, OP_FREE, c1, pg, vec);
        wait_done(4, OP_ALLOC, c2, pg, vec);
        check("prio_order", c2 > c1, 1'b1);

        // ack stall: operands captured at grant stay put while inputs change
        ack_delay = 10;
        raise(1, OP_SET, 10'h0AB, 4'd5);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = core_req;
        end
        check("stall_req_seen", got, 1'b1);
        pg_use[1*A +: A]  = 10'h111;
        ucnt_in[1*U +: U] = 4'd2;
        for (int t = 0; t < 10; t++) begin
            if (t > 0) @(negedge clk);
            check("stall_hold", {core_req, busy, core_op, core_pgaddr, core_usecnt},
                  {1'b1, 1'b1, OP_SET, 10'h0AB, 4'd5});
        end
        wait_done(1, OP_SET, c1, pg, vec);
        check("stall_done_vec", vec, 7'b0000010);

        // reset during REQ: request drops at once, no done, port 0 wins next
        ack_delay = 5;
        alloc_r[3] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = core_req;
        end
        check("rstreq_seen", got, 1'b1);
        #2 rst = 1'b1;
        #1 check("rst_async_req", {core_req, busy}, 2'b00);
        alloc_r = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ack_delay = 0;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_done", {alloc_done, free_done, force_done, set_done}, '0);
        end
        raise(5, OP_ALLOC, '0, '0);
        raise(0, OP_ALLOC, '0, '0);
        wait_done(0, OP_ALLOC, c1, pg, vec);
        wait_done(5, OP_ALLOC, c2, pg, vec);
        check("rst_first_grant", c2 > c1, 1'b1);

        // randomised mixed traffic on all ports against the pool model
        model_en = 1'b1;
        ack_rand = 1'b1;
        fork
            port_job(0);
            port_job(1);
            port_job(2);
            port_job(3);
            port_job(4);
            port_job(5);
            port_job(6);
        join
        ack_rand = 1'b0;
        repeat (4) @(negedge clk);
        check("pool_free_count", free_pages.size(), POOL);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
